// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// quotient to LO and remainder to HI, with busy/done handshake toward the pipeline.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [4:0]  count;
  logic        q_neg;
  logic        r_neg;
  logic        dz;

  logic [32:0] trial;
  logic        ge;
  logic [31:0] diff;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  // The stored remainder is always below the divisor, so only the 33-bit trial needs
  // the extra bit; when the trial wins the difference fits back into 32 bits.
  always_comb begin
    trial = {rem, dvd[31]};
    ge    = (trial >= {1'b0, dvs});
    diff  = trial[31:0] - dvs;
    abs_a = (signed_div && a[31]) ? (32'd0 - a) : a;
    abs_b = (signed_div && b[31]) ? (32'd0 - b) : b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      count     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !annul) begin
            dvs   <= abs_b;
            rem   <= '0;
            count <= '0;
            q_neg <= signed_div & (a[31] ^ b[31]);
            r_neg <= signed_div & a[31];
            // Divide-by-zero keeps the raw dividend so it can be returned as the remainder.
            if (b == 32'd0) begin
              dvd   <= a;
              dz    <= 1'b1;
              state <= S_DONE;
            end else begin
              dvd   <= abs_a;
              dz    <= 1'b0;
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (annul) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            rem   <= ge ? diff : trial[31:0];
            dvd   <= {dvd[30:0], ge};
            count <= count + 5'd1;
            if (count == 5'd31) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          quotient  <= dz ? 32'hFFFF_FFFF : (q_neg ? (32'd0 - dvd) : dvd);
          remainder <= dz ? dvd : (r_neg ? (32'd0 - rem) : rem);
          div_zero  <= dz;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: hand-computed quotients/remainders,
// latency, divide-by-zero, annul, async reset and ignored start requests.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  int busy_cnt;
  int done_cnt;

  div_iter dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .a(a), .b(b),
    .annul(annul), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request, then counts edges until done (bounded) and busy cycles seen.
  task automatic applyStimulus(input logic sd, input logic [31:0] av, input logic [31:0] bv);
    signed_div = sd;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input int exp_lat, input int exp_busy,
                             input logic [31:0] q, input logic [31:0] r, input logic dzv);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    checkOutput({tag, "_quotient"}, quotient, q);
    checkOutput({tag, "_remainder"}, remainder, r);
    checkOutput({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, dzv});
    checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    tick();
    checkOutput({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  task automatic countDones(input int cycles);
    done_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) done_cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    a = '0;
    b = '0;
    annul = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_div_zero", {31'd0, div_zero}, 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);

    applyStimulus(1'b0, 32'd100, 32'd7);
    checkResult("u100_7", 33, 32, 32'd14, 32'd2, 1'b0);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    checkResult("s_m7_2", 33, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

    applyStimulus(1'b0, 32'hFFFF_FFF9, 32'd2);
    checkResult("u_fff9_2", 33, 32, 32'h7FFF_FFFC, 32'd1, 1'b0);

    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkResult("s_overflow", 33, 32, 32'h8000_0000, 32'd0, 1'b0);

    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFD);
    checkResult("s_7_m3", 33, 32, 32'hFFFF_FFFE, 32'd1, 1'b0);

    applyStimulus(1'b0, 32'd5, 32'd0);
    checkResult("u5_0", 1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);

    // Annul in the tenth RUN cycle: result registers keep the divide-by-zero values.
    signed_div = 1'b0;
    a = 32'd1000;
    b = 32'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checkOutput("annul_busy_before", {31'd0, busy}, 32'd1);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    checkOutput("annul_busy_after", {31'd0, busy}, 32'd0);
    countDones(40);
    checkOutput("annul_no_done", 32'(done_cnt), 32'd0);
    checkOutput("annul_hold_quotient", quotient, 32'hFFFF_FFFF);
    checkOutput("annul_hold_remainder", remainder, 32'd5);
    checkOutput("annul_hold_div_zero", {31'd0, div_zero}, 32'd1);

    applyStimulus(1'b0, 32'd9, 32'd3);
    checkResult("u9_3", 33, 32, 32'd3, 32'd0, 1'b0);

    // start together with annul in IDLE is dropped.
    a = 32'd50;
    b = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    tick();
    start = 1'b0;
    annul = 1'b0;
    checkOutput("drop_busy", {31'd0, busy}, 32'd0);
    countDones(40);
    checkOutput("drop_no_done", 32'(done_cnt), 32'd0);
    checkOutput("drop_quotient_hold", quotient, 32'd3);

    // Asynchronous reset between edges in the middle of RUN.
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_quotient", quotient, 32'd0);
    checkOutput("arst_remainder", remainder, 32'd0);
    rst = 1'b0;
    tick();
    countDones(40);
    checkOutput("arst_no_done", 32'(done_cnt), 32'd0);

    // A second start (with a zero divisor) during RUN must be ignored.
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    a = 32'd1;
    b = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    countDones(60);
    checkOutput("ignore_start_one_done", 32'(done_cnt), 32'd1);
    checkOutput("ignore_start_quotient", quotient, 32'd14);
    checkOutput("ignore_start_remainder", remainder, 32'd2);
    checkOutput("ignore_start_div_zero", {31'd0, div_zero}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
